// File: rtl/pipe_sequencer_if.sv
// Sequencer <-> datapath bundle: fetch controls in, PC/valid/status out.
interface pipe_sequencer_if #(
    parameter int XLEN   = 32,
    parameter int STAGES = 5,
    parameter int EXC_W  = 8,
    parameter int CNT_W  = 64
);
    logic              stall_in;
    logic              br_enable;
    logic [XLEN-1:0]   br_target;
    logic              halt_req;
    logic [EXC_W-1:0]  wb_exception;
    logic [XLEN-1:0]   pc_if;
    logic [STAGES-1:0] pc_valid;
    logic              br_trigger;
    logic              halted;
    logic [EXC_W-1:0]  halt_cause;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        input  stall_in, br_enable, br_target,
        input  halt_req, wb_exception,
        output pc_if, pc_valid, br_trigger,
        output halted, halt_cause,
        output cycle_count, retired_count
    );

    modport slave (
        output stall_in, br_enable, br_target,
        output halt_req, wb_exception,
        input  pc_if, pc_valid, br_trigger,
        input  halted, halt_cause,
        input  cycle_count, retired_count
    );
endinterface

// File: rtl/pipe_sequencer.sv
// Fetch PC, per-stage valid tracking, squash/stall/halt/drain sequencing
// and cycle/retire counters for the pipelined MIPS core.
module pipe_sequencer #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h00003000,
    parameter int               STAGES    = 5,
    parameter int               BR_SHADOW = 1,
    parameter int               EXC_W     = 8,
    parameter logic [EXC_W-1:0] EXC_STALL = 8'h01,
    parameter int               CNT_W     = 64
) (
    input logic               clk,
    input logic               rst,
    pipe_sequencer_if.master  bus
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [STAGES-1:0] BR_KEEP =
        {STAGES{1'b1}} << BR_SHADOW;

    logic [1:0]        r_state;
    logic [XLEN-1:0]   r_pc;
    logic [STAGES-1:0] r_pv;
    logic              r_brt;
    logic              r_halted;
    logic [EXC_W-1:0]  r_cause;
    logic [CNT_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_ret;

    logic              w_last;
    logic              w_exc;
    logic              w_retire;
    logic [STAGES-1:0] w_pv_lin;
    logic [STAGES-1:0] w_pv_drain;
    logic [STAGES-1:0] w_pv_stall;

    assign w_last   = r_pv[STAGES-1];
    assign w_exc    = w_last
                   && (bus.wb_exception != '0)
                   && (bus.wb_exception != EXC_STALL);
    assign w_retire = w_last && !w_exc;

    assign w_pv_lin   = {r_pv[STAGES-2:0], 1'b1};
    assign w_pv_drain = {r_pv[STAGES-2:0], 1'b0};

    // Stall: stage 0 holds its instruction, a bubble enters stage 1.
    always_comb begin
        w_pv_stall    = w_pv_drain;
        w_pv_stall[1] = 1'b0;
        w_pv_stall[0] = r_pv[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_pv     <= '0;
            r_brt    <= 1'b0;
            r_halted <= 1'b0;
            r_cause  <= '0;
            r_cyc    <= CNT_W'(1);
            r_ret    <= '0;
        end else if (r_state != S_HALT) begin
            r_cyc <= r_cyc + CNT_W'(1);
            r_brt <= 1'b0;
            if (w_retire)
                r_ret <= r_ret + CNT_W'(1);
            if (w_exc) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
                r_cause  <= bus.wb_exception;
                r_pv     <= '0;
            end else if (r_state == S_DRAIN) begin
                r_pv <= w_pv_drain;
                if (w_pv_drain == '0) begin
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                    r_cause  <= '0;
                end
            end else begin
                if (bus.halt_req)
                    r_state <= S_DRAIN;
                if (bus.stall_in) begin
                    r_pv <= w_pv_stall;
                end else if (bus.br_enable) begin
                    r_pc  <= bus.br_target;
                    r_brt <= 1'b1;
                    r_pv  <= w_pv_lin & BR_KEEP;
                end else begin
                    r_pc <= r_pc + XLEN'(4);
                    r_pv <= w_pv_lin;
                end
            end
        end
    end

    assign bus.pc_if         = r_pc;
    assign bus.pc_valid      = r_pv;
    assign bus.br_trigger    = r_brt;
    assign bus.halted        = r_halted;
    assign bus.halt_cause    = r_cause;
    assign bus.cycle_count   = r_cyc;
    assign bus.retired_count = r_ret;
endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: behavioural model compared every
// cycle, plus hand-computed literal checkpoints.
module tb_pipe_sequencer;
    localparam int XLEN      = 32;
    localparam int STAGES    = 5;
    localparam int BR_SHADOW = 1;
    localparam int EXC_W     = 8;
    localparam int CNT_W     = 64;
    localparam logic [7:0] EXC_STALL = 8'h01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_sequencer_if #(
        .XLEN(XLEN), .STAGES(STAGES),
        .EXC_W(EXC_W), .CNT_W(CNT_W)
    ) bus ();

    pipe_sequencer #(
        .XLEN(XLEN), .RESET_PC(32'h00003000),
        .STAGES(STAGES), .BR_SHADOW(BR_SHADOW),
        .EXC_W(EXC_W), .EXC_STALL(EXC_STALL),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    // Model: an array of live flags, one per stage, plus mode flags.
    logic [31:0] m_pc;
    bit          m_live [STAGES];
    bit          m_brt;
    bit          m_halted;
    bit          m_draining;
    logic [7:0]  m_cause;
    logic [63:0] m_cyc;
    logic [63:0] m_ret;

    logic [31:0] pc_s;
    logic [63:0] ret_s;
    logic [63:0] cyc_s;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [STAGES-1:0] m_vec();
        logic [STAGES-1:0] v;
        for (int k = 0; k < STAGES; k++) v[k] = m_live[k];
        return v;
    endfunction

    task automatic model_step();
        bit oldest;
        bit bad;
        bit any;
        if (rst) begin
            m_pc = 32'h00003000;
            for (int k = 0; k < STAGES; k++) m_live[k] = 0;
            m_brt = 0; m_halted = 0; m_draining = 0;
            m_cause = 8'h00; m_cyc = 64'd1; m_ret = 64'd0;
            return;
        end
        if (m_halted) return;
        m_cyc = m_cyc + 64'd1;
        m_brt = 0;
        oldest = m_live[STAGES-1];
        bad = oldest && bus.wb_exception != 8'h00
                     && bus.wb_exception != EXC_STALL;
        if (oldest && !bad) m_ret = m_ret + 64'd1;
        if (bad) begin
            m_halted = 1;
            m_cause = bus.wb_exception;
            for (int k = 0; k < STAGES; k++) m_live[k] = 0;
        end else if (m_draining) begin
            any = 0;
            for (int k = STAGES-1; k > 0; k--) begin
                m_live[k] = m_live[k-1];
                any |= m_live[k];
            end
            m_live[0] = 0;
            if (!any) begin
                m_halted = 1;
                m_cause = 8'h00;
            end
        end else begin
            if (bus.halt_req) m_draining = 1;
            if (bus.stall_in) begin
                for (int k = STAGES-1; k > 1; k--)
                    m_live[k] = m_live[k-1];
                m_live[1] = 0;
            end else begin
                for (int k = STAGES-1; k > 0; k--)
                    m_live[k] = m_live[k-1];
                m_live[0] = 1;
                if (bus.br_enable) begin
                    m_pc = bus.br_target;
                    m_brt = 1;
                    for (int k = 0; k < BR_SHADOW; k++)
                        m_live[k] = 0;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic idle_in();
        bus.stall_in = 0; bus.br_enable = 0;
        bus.br_target = '0; bus.halt_req = 0;
        bus.wb_exception = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_if", 64'(bus.pc_if), 64'(m_pc));
            chk("pc_valid", 64'(bus.pc_valid), 64'(m_vec()));
            chk("br_trigger", 64'(bus.br_trigger), 64'(m_brt));
            chk("halted", 64'(bus.halted), 64'(m_halted));
            chk("halt_cause", 64'(bus.halt_cause), 64'(m_cause));
            chk("cycle_count", bus.cycle_count, m_cyc);
            chk("retired_count", bus.retired_count, m_ret);
        end
    end

    initial begin
        idle_in();
        rst = 1;
        cyc();
        rst = 0;
        chk_en = 1;
        chk("rst pc", 64'(bus.pc_if), 64'h3000);
        chk("rst valid", 64'(bus.pc_valid), 64'h0);
        chk("rst cycles", bus.cycle_count, 64'd1);
        chk("rst retired", bus.retired_count, 64'd0);
        chk("rst halted", 64'(bus.halted), 64'd0);

        cyc(4);
        chk("lin pc", 64'(bus.pc_if), 64'h3010);
        chk("lin valid", 64'(bus.pc_valid), 64'h0F);
        chk("lin cycles", bus.cycle_count, 64'd5);
        cyc(2);
        chk("lin retired", bus.retired_count, 64'd1);

        rst = 1; cyc(); rst = 0;
        cyc(2);
        chk("pre-stall pc", 64'(bus.pc_if), 64'h3008);
        chk("pre-stall valid", 64'(bus.pc_valid), 64'h03);
        bus.stall_in = 1; bus.br_enable = 1;
        bus.br_target = 32'h5000;
        cyc(2);
        chk("stall pc", 64'(bus.pc_if), 64'h3008);
        chk("stall valid", 64'(bus.pc_valid), 64'h09);
        chk("stall brt", 64'(bus.br_trigger), 64'd0);
        idle_in();

        cyc(5);
        chk("full valid", 64'(bus.pc_valid), 64'h1F);
        bus.br_enable = 1; bus.br_target = 32'h3100;
        cyc();
        idle_in();
        chk("br pc", 64'(bus.pc_if), 64'h3100);
        chk("br valid", 64'(bus.pc_valid), 64'h1E);
        chk("br trig", 64'(bus.br_trigger), 64'd1);
        cyc();
        chk("post-br pc", 64'(bus.pc_if), 64'h3104);
        chk("post-br trig", 64'(bus.br_trigger), 64'd0);

        cyc(5);
        ret_s = bus.retired_count;
        bus.wb_exception = EXC_STALL;
        cyc();
        idle_in();
        chk("benign halted", 64'(bus.halted), 64'd0);
        chk("benign retire", bus.retired_count, ret_s + 64'd1);

        bus.halt_req = 1;
        cyc();
        idle_in();
        pc_s = bus.pc_if;
        ret_s = bus.retired_count;
        bus.stall_in = 1; bus.br_enable = 1;
        bus.br_target = 32'h7000;
        cyc(4);
        chk("drain not yet", 64'(bus.halted), 64'd0);
        cyc();
        idle_in();
        chk("drain valid", 64'(bus.pc_valid), 64'h0);
        chk("drain halted", 64'(bus.halted), 64'd1);
        chk("drain cause", 64'(bus.halt_cause), 64'h0);
        chk("drain retired", bus.retired_count, ret_s + 64'd5);
        chk("drain pc", 64'(bus.pc_if), 64'(pc_s));
        cyc_s = bus.cycle_count;
        cyc(2);
        chk("halt frozen", bus.cycle_count, cyc_s);

        rst = 1; cyc(); rst = 0;
        chk("rehalt pc", 64'(bus.pc_if), 64'h3000);
        chk("rehalt halted", 64'(bus.halted), 64'd0);
        chk("rehalt cycles", bus.cycle_count, 64'd1);

        bus.wb_exception = 8'h04;
        cyc();
        idle_in();
        chk("exc ignored", 64'(bus.halted), 64'd0);
        cyc(4);
        bus.wb_exception = 8'h04;
        cyc();
        idle_in();
        chk("exc halted", 64'(bus.halted), 64'd1);
        chk("exc cause", 64'(bus.halt_cause), 64'h04);
        chk("exc valid", 64'(bus.pc_valid), 64'h0);
        chk("exc retired", bus.retired_count, 64'd0);
        pc_s = bus.pc_if;
        cyc_s = bus.cycle_count;
        cyc(3);
        chk("exc cyc frozen", bus.cycle_count, cyc_s);
        chk("exc ret frozen", bus.retired_count, 64'd0);
        chk("exc pc held", 64'(bus.pc_if), 64'(pc_s));

        rst = 1; cyc(); rst = 0;
        bus.br_enable = 1; bus.br_target = 32'hFFFFFFFC;
        cyc();
        idle_in();
        chk("wrap pre", 64'(bus.pc_if), 64'hFFFFFFFC);
        cyc();
        chk("wrap pc", 64'(bus.pc_if), 64'h0);
        cyc(3);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
